// File: rtl/vae_ctrl_pkg.sv
// vae_ctrl_pkg: state encoding, block sizing and output pad shared by the VAE batch controller
package vae_ctrl_pkg;
    localparam int WORDS = 9;
    localparam int CNT_W = 4;
    localparam logic [47:0] PAD = 48'd0;
    typedef enum logic [3:0] {
        IDLE, LD_WM, LD_WV, LD_W3, LD_X, START, WAIT, RD, FLUSH
    } state_t;
endpackage

// File: rtl/axis_skid2.sv
// axis_skid2: two-entry AXI-Stream output buffer; producer must respect count so it never overflows
module axis_skid2 (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic [63:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [1:0]  count
);
    logic [64:0] mem [2];
    logic        wp, rp, pop;
    assign pop = m_tvalid & m_tready;
    assign m_tvalid = count != 2'd0;
    assign {m_tlast, m_tdata} = mem[rp];
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wp] <= {in_last, in_data};
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
endmodule

// File: rtl/axis_vae_batch_ctrl.sv
// axis_vae_batch_ctrl: loads weights and samples from AXI-Stream into VAE BRAMs,
// runs the core once per sample and streams each result block out.
module axis_vae_batch_ctrl #(
    parameter int WORDS = vae_ctrl_pkg::WORDS,
    parameter int CNT_W = vae_ctrl_pkg::CNT_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    input  logic [7:0]       cfg_batch,
    input  logic             cfg_reload_wb,
    output logic             wb2_m_ena,
    output logic [CNT_W-1:0] wb2_m_addra,
    output logic [63:0]      wb2_m_dina,
    output logic [7:0]       wb2_m_wea,
    output logic             wb2_v_ena,
    output logic [CNT_W-1:0] wb2_v_addra,
    output logic [63:0]      wb2_v_dina,
    output logic [7:0]       wb2_v_wea,
    output logic             wb3_ena,
    output logic [CNT_W-1:0] wb3_addra,
    output logic [63:0]      wb3_dina,
    output logic [7:0]       wb3_wea,
    output logic             xin_ena,
    output logic [CNT_W-1:0] xin_addra,
    output logic [15:0]      xin_dina,
    output logic [7:0]       xin_wea,
    output logic             xout_enb,
    output logic [CNT_W-1:0] xout_addrb,
    input  logic [15:0]      xout_doutb,
    input  logic             vae_ready,
    input  logic             vae_done,
    output logic             vae_start,
    output logic             busy,
    output logic [7:0]       sample_idx,
    output logic             err_tlast
);
    import vae_ctrl_pkg::*;
    localparam logic [CNT_W-1:0] W_END = CNT_W'(WORDS - 1);
    state_t           state;
    logic [CNT_W-1:0] wcnt, rd_addr;
    logic [7:0]       batch;
    logic             wb_loaded, armed, rd_pend, rd_last;
    logic [1:0]       occ;
    logic             hs, w_last, s_last, tlast_exp, issue;
    assign s_axis_tready = state inside {LD_WM, LD_WV, LD_W3, LD_X};
    assign hs        = s_axis_tvalid & s_axis_tready;
    assign w_last    = wcnt == W_END;
    assign s_last    = sample_idx == batch - 8'd1;
    assign tlast_exp = state == LD_X && w_last && s_last;
    // at most two words may be buffered or in flight from the 1-cycle BRAM
    assign issue     = state == RD && (occ == 2'd0 || (occ == 2'd1 && !rd_pend));
    assign busy      = state != IDLE;
    assign wb2_m_ena   = hs && state == LD_WM;
    assign wb2_v_ena   = hs && state == LD_WV;
    assign wb3_ena     = hs && state == LD_W3;
    assign xin_ena     = hs && state == LD_X;
    assign wb2_m_wea   = {8{wb2_m_ena}};
    assign wb2_v_wea   = {8{wb2_v_ena}};
    assign wb3_wea     = {8{wb3_ena}};
    assign xin_wea     = {8{xin_ena}};
    assign wb2_m_addra = wcnt;
    assign wb2_v_addra = wcnt;
    assign wb3_addra   = wcnt;
    assign xin_addra   = wcnt;
    assign wb2_m_dina  = s_axis_tdata;
    assign wb2_v_dina  = s_axis_tdata;
    assign wb3_dina    = s_axis_tdata;
    assign xin_dina    = s_axis_tdata[63:48];
    assign xout_enb    = issue;
    assign xout_addrb  = rd_addr;
    axis_skid2 u_skid (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_valid (rd_pend),
        .in_data  ({xout_doutb, PAD}),
        .in_last  (rd_last),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tlast  (m_axis_tlast),
        .m_tready (m_axis_tready),
        .count    (occ)
    );
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state      <= IDLE;
            wcnt       <= '0;
            rd_addr    <= '0;
            batch      <= 8'd0;
            sample_idx <= 8'd0;
            wb_loaded  <= 1'b0;
            armed      <= 1'b0;
            vae_start  <= 1'b0;
            rd_pend    <= 1'b0;
            rd_last    <= 1'b0;
            err_tlast  <= 1'b0;
        end else begin
            vae_start <= 1'b0;
            rd_pend   <= issue;
            rd_last   <= issue && rd_addr == W_END && s_last;
            if (hs) begin
                wcnt <= w_last ? '0 : wcnt + 1'b1;
                if (s_axis_tlast != tlast_exp) err_tlast <= 1'b1;
            end
            case (state)
                IDLE: if (s_axis_tvalid) begin
                    batch      <= cfg_batch == 8'd0 ? 8'd1 : cfg_batch;
                    sample_idx <= 8'd0;
                    wcnt       <= '0;
                    state      <= (cfg_reload_wb || !wb_loaded) ? LD_WM : LD_X;
                end
                LD_WM: if (hs && w_last) state <= LD_WV;
                LD_WV: if (hs && w_last) state <= LD_W3;
                LD_W3: if (hs && w_last) begin
                    state     <= LD_X;
                    wb_loaded <= 1'b1;
                end
                LD_X: if (hs && w_last) state <= START;
                START: if (vae_ready) begin
                    vae_start <= 1'b1;
                    armed     <= 1'b0;
                    state     <= WAIT;
                end
                // done is not trusted in the pulse cycle or the one right after it
                WAIT: if (!vae_start) begin
                    armed <= 1'b1;
                    if (armed && vae_done) state <= RD;
                end
                RD: if (issue) begin
                    rd_addr <= rd_addr == W_END ? '0 : rd_addr + 1'b1;
                    if (rd_addr == W_END) state <= FLUSH;
                end
                FLUSH: if (occ == 2'd0 && !rd_pend) begin
                    if (s_last) state <= IDLE;
                    else begin
                        sample_idx <= sample_idx + 8'd1;
                        state      <= LD_X;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_axis_vae_batch_ctrl.sv
// tb_axis_vae_batch_ctrl: random batches against a block-level model with scoreboarded writes and outputs
module tb_axis_vae_batch_ctrl;
    localparam int W = 9;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b0;
    logic [7:0]  cfg_batch = 8'd1;
    logic        cfg_reload_wb = 1'b0;
    logic        wb2_m_ena, wb2_v_ena, wb3_ena, xin_ena, xout_enb;
    logic [3:0]  wb2_m_addra, wb2_v_addra, wb3_addra, xin_addra, xout_addrb;
    logic [63:0] wb2_m_dina, wb2_v_dina, wb3_dina;
    logic [7:0]  wb2_m_wea, wb2_v_wea, wb3_wea, xin_wea;
    logic [15:0] xin_dina;
    logic [15:0] xout_doutb = 16'd0;
    logic        vae_ready = 1'b1, vae_done = 1'b0, vae_start, busy, err_tlast;
    logic [7:0]  sample_idx;

    axis_vae_batch_ctrl dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .cfg_batch(cfg_batch), .cfg_reload_wb(cfg_reload_wb),
        .wb2_m_ena(wb2_m_ena), .wb2_m_addra(wb2_m_addra), .wb2_m_dina(wb2_m_dina), .wb2_m_wea(wb2_m_wea),
        .wb2_v_ena(wb2_v_ena), .wb2_v_addra(wb2_v_addra), .wb2_v_dina(wb2_v_dina), .wb2_v_wea(wb2_v_wea),
        .wb3_ena(wb3_ena), .wb3_addra(wb3_addra), .wb3_dina(wb3_dina), .wb3_wea(wb3_wea),
        .xin_ena(xin_ena), .xin_addra(xin_addra), .xin_dina(xin_dina), .xin_wea(xin_wea),
        .xout_enb(xout_enb), .xout_addrb(xout_addrb), .xout_doutb(xout_doutb),
        .vae_ready(vae_ready), .vae_done(vae_done), .vae_start(vae_start),
        .busy(busy), .sample_idx(sample_idx), .err_tlast(err_tlast)
    );

    always #5 aclk = ~aclk;

    int          n_chk = 0, n_fail = 0;
    int          n_out, n_wt, n_xin, n_start, core_sample, cur_batch, exp_wt, rmode = 0;
    logic        loaded = 1'b0, exp_err = 1'b0;
    logic [64:0] exp_out[$];
    logic [69:0] exp_wr[$];
    logic [15:0] xout_mem[16];

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wr_check(input int p, input logic [3:0] a, input logic [63:0] d, input logic [7:0] we);
        logic [69:0] e;
        check("wea", we, 8'hff);
        if (p < 3) n_wt++;
        else n_xin++;
        if (exp_wr.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wr_extra: port %0d addr %0d data %0h, none expected", p, a, d);
        end else begin
            e = exp_wr.pop_front();
            check("bram_write", {2'(p), a, d}, e);
        end
    endtask

    // output BRAM with one cycle of read latency
    always @(posedge aclk) if (xout_enb) xout_doutb <= xout_mem[xout_addrb];

    always @(posedge aclk) begin
        #1;
        case (rmode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = !m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // monitor: BRAM writes, result stream and start pulses
    logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_start = 1'b0, prev_vrdy = 1'b0;
    logic [63:0] prev_data = '0;
    logic [64:0] eo;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_vld && !prev_rdy) begin
                check("tvalid_hold", m_axis_tvalid, 1'b1);
                check("tdata_hold", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_out++;
                if (exp_out.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_extra: got %0h, none expected", m_axis_tdata);
                end else begin
                    eo = exp_out.pop_front();
                    check("out_word", {m_axis_tlast, m_axis_tdata}, eo);
                end
            end
            if (wb2_m_ena) wr_check(0, wb2_m_addra, wb2_m_dina, wb2_m_wea);
            if (wb2_v_ena) wr_check(1, wb2_v_addra, wb2_v_dina, wb2_v_wea);
            if (wb3_ena) wr_check(2, wb3_addra, wb3_dina, wb3_wea);
            if (xin_ena) wr_check(3, xin_addra, {48'd0, xin_dina}, xin_wea);
            if (vae_start) begin
                n_start++;
                check("start_pulse_width", prev_start, 1'b0);
                check("start_needs_ready", prev_vrdy, 1'b1);
            end
        end
        prev_vld   = m_axis_tvalid & aresetn;
        prev_rdy   = m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_start = vae_start;
        prev_vrdy  = vae_ready;
    end

    // core model: on each start produce a fresh result block, then signal done
    initial forever begin
        @(negedge aclk);
        if (aresetn && vae_start) begin
            for (int i = 0; i < W; i++) begin
                xout_mem[i] = 16'($urandom);
                exp_out.push_back({i == W - 1 && core_sample == cur_batch - 1, xout_mem[i], 48'd0});
            end
            core_sample++;
            repeat ($urandom_range(3, 8)) @(posedge aclk);
            #1 vae_done = 1'b1;
            @(posedge aclk);
            #1 vae_done = 1'b0;
        end
    end

    task automatic drive_word(input logic [63:0] d, input logic l);
        int  n = 0;
        logic hit = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        while (!hit && n < 3000) begin
            @(negedge aclk);
            hit = s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL s_handshake_timeout: tready %0b after %0d cycles, required 1", s_axis_tready, n);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_batch(input logic [7:0] b, input logic rl, input int bad);
        int          be;
        logic        ldw;
        logic [63:0] d;
        logic [63:0] words[$];
        logic        lasts[$];
        be  = (b == 8'd0) ? 1 : int'(b);
        ldw = rl || !loaded;
        cur_batch = be;
        core_sample = 0;
        n_out = 0; n_wt = 0; n_xin = 0; n_start = 0;
        if (ldw)
            for (int p = 0; p < 3; p++)
                for (int i = 0; i < W; i++) begin
                    d = {$urandom, $urandom};
                    words.push_back(d);
                    lasts.push_back(1'b0);
                    exp_wr.push_back({2'(p), 4'(i), d});
                end
        for (int s = 0; s < be; s++)
            for (int i = 0; i < W; i++) begin
                d = {$urandom, $urandom};
                words.push_back(d);
                lasts.push_back((s == be - 1 && i == W - 1) || (s == 0 && i == bad));
                exp_wr.push_back({2'd3, 4'(i), 48'd0, d[63:48]});
            end
        exp_wt = ldw ? 3 * W : 0;
        if (bad >= 0) exp_err = 1'b1;
        if (ldw) loaded = 1'b1;
        cfg_batch = b;
        cfg_reload_wb = rl;
        foreach (words[k]) drive_word(words[k], lasts[k]);
    endtask

    task automatic finish_batch();
        int n = 0;
        while (busy && n < 20000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("batch_done", busy, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        check("outputs", n_out, W * cur_batch);
        check("wt_writes", n_wt, exp_wt);
        check("xin_writes", n_xin, W * cur_batch);
        check("starts", n_start, cur_batch);
        check("err_tlast", err_tlast, exp_err);
        check("out_q_empty", exp_out.size(), 0);
        check("wr_q_empty", exp_wr.size(), 0);
        check("sample_idx_end", sample_idx, cur_batch - 1);
    endtask

    initial begin
        int n;
        #22;
        check("rst_outputs", {s_axis_tready, m_axis_tvalid, vae_start, wb2_m_ena, wb2_v_ena, wb3_ena, xin_ena,
                              xout_enb, busy, err_tlast, wb2_m_wea, xin_wea}, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        send_batch(8'd1, 1'b0, -1); finish_batch();
        send_batch(8'd2, 1'b0, -1); finish_batch();
        rmode = 1;
        send_batch(8'd1, 1'b0, -1); finish_batch();
        rmode = 0;
        send_batch(8'd1, 1'b0, 5); finish_batch();
        rmode = 2;
        send_batch(8'd3, 1'b1, -1); finish_batch();
        send_batch(8'd0, 1'b0, -1); finish_batch();
        rmode = 0;
        vae_ready = 1'b0;
        send_batch(8'd1, 1'b0, -1);
        repeat (10) begin
            @(negedge aclk);
            check("start_held", vae_start, 1'b0);
        end
        @(posedge aclk);
        #1 vae_ready = 1'b1;
        finish_batch();
        // abort a batch while the core is running
        send_batch(8'd1, 1'b0, -1);
        n = 0;
        while (!vae_start && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("start_seen", vae_start, 1'b1);
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("rst_mid_outputs", {s_axis_tready, m_axis_tvalid, vae_start, wb2_m_ena, wb2_v_ena, wb3_ena, xin_ena,
                                  xout_enb, busy, err_tlast, wb2_m_wea, xin_wea}, 0);
        repeat (12) @(posedge aclk);
        #1;
        exp_out.delete();
        exp_wr.delete();
        loaded = 1'b0;
        exp_err = 1'b0;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("err_after_rst", err_tlast, 1'b0);
        send_batch(8'd1, 1'b0, -1); finish_batch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, test incomplete");
        $fatal(1, "watchdog");
    end
endmodule
